// File: rtl/cyclone_ddio_in_if.sv
// Word output handshake between cyclone_ddio_in and its consumer.
//   word_out   : two assembled DDR beats, first beat in the LSBs
//   word_valid : holding register is FULL
//   word_ready : consumer accepts word_out this cycle
// master = producer (cyclone_ddio_in), slave = consumer.
interface cyclone_ddio_in_if #(
  parameter int width = 1
);
  logic [4*width-1:0] word_out;
  logic               word_valid;
  logic               word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/cyclone_ddio_in.sv
// DDR input capture with two-beat word assembly and a single-entry output
// holding register.
//   inclock    : single clock; rising and falling edges both sample datain
//   aclr_n     : asynchronous active-low reset
//   inclocken  : capture enable, sampled on the rising edge
//   datain     : DDR pad data
//   align      : pulse restarting word assembly at slot 0
//   dataout_h  : rising-edge sample of the last beat
//   dataout_l  : falling-edge sample of the last beat
//   beat_valid : dataout_h/dataout_l hold a new beat this cycle
//   overflow   : sticky, a completed word was dropped
//   word_if    : word_out / word_valid / word_ready handshake
//
// Assembler states:
//   state | meaning
//   SLOT0 | next beat becomes the low half of the word (word_lo)
//   SLOT1 | next beat completes the word
module cyclone_ddio_in #(
  parameter int    width         = 1,
  parameter string power_up_high = "off"
) (
  input  logic              inclock,
  input  logic              aclr_n,
  input  logic              inclocken,
  input  logic [width-1:0]  datain,
  input  logic              align,
  output logic [width-1:0]  dataout_h,
  output logic [width-1:0]  dataout_l,
  output logic              beat_valid,
  output logic              overflow,
  cyclone_ddio_in_if.master word_if
);

  localparam logic               rst_bit = (power_up_high == "on");
  localparam logic [width-1:0]   rst_w   = {width{rst_bit}};
  localparam logic [2*width-1:0] rst_2w  = {(2*width){rst_bit}};
  localparam logic [4*width-1:0] rst_4w  = {(4*width){rst_bit}};

  typedef enum logic {SLOT0 = 1'b0, SLOT1 = 1'b1} state_t;

  logic [width-1:0]   rise_reg;
  logic [width-1:0]   fall_reg;
  logic               cap_en;
  state_t             state;
  logic [2*width-1:0] word_lo;
  logic               word_done;
  logic [4*width-1:0] word_new;

  // Rising-edge capture; cap_en remembers that this edge was enabled so the
  // following falling edge and the next rising edge complete the pair.
  always_ff @(posedge inclock or negedge aclr_n) begin
    if (!aclr_n) begin
      rise_reg   <= rst_w;
      cap_en     <= 1'b0;
      dataout_h  <= rst_w;
      dataout_l  <= rst_w;
      beat_valid <= 1'b0;
    end else begin
      cap_en <= inclocken;
      if (inclocken) begin
        rise_reg <= datain;
      end
      if (cap_en) begin
        dataout_h <= rise_reg;
        dataout_l <= fall_reg;
      end
      beat_valid <= cap_en;
    end
  end

  always_ff @(negedge inclock or negedge aclr_n) begin
    if (!aclr_n) begin
      fall_reg <= rst_w;
    end else if (cap_en) begin
      fall_reg <= datain;
    end
  end

  // A beat arriving together with align restarts at slot 0, so it never
  // completes a word.
  assign word_done = beat_valid && (state == SLOT1) && !align;
  assign word_new  = {dataout_l, dataout_h, word_lo};

  always_ff @(posedge inclock or negedge aclr_n) begin
    if (!aclr_n) begin
      state              <= SLOT0;
      word_lo            <= rst_2w;
      word_if.word_out   <= rst_4w;
      word_if.word_valid <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      if (beat_valid) begin
        if (align || (state == SLOT0)) begin
          word_lo <= {dataout_l, dataout_h};
          state   <= SLOT1;
        end else begin
          state <= SLOT0;
        end
      end else if (align) begin
        state <= SLOT0;
      end

      // Holding register: a draining consumer frees the slot in the same
      // cycle, so a completed word can refill it without a bubble.
      if (word_done) begin
        if (!word_if.word_valid || word_if.word_ready) begin
          word_if.word_out   <= word_new;
          word_if.word_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (word_if.word_valid && word_if.word_ready) begin
        word_if.word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cyclone_ddio_in.md
CYCLONE_DDIO_IN -- requirements
Module: cyclone_ddio_in

Interface
REQ-001 The block SHALL have parameter width, default 1, meaning pad bits per DDR beat.
REQ-002 The block SHALL have parameter power_up_high, default "off"; "on" means every capture and output data register resets to all-ones.
REQ-003 The block SHALL have port inclock, input, 1, meaning the single clock; rising and falling edges both used.
REQ-004 The block SHALL have port aclr_n, input, 1, meaning asynchronous, active-low reset.
REQ-005 The block SHALL have port inclocken, input, 1, meaning capture enable sampled on the rising edge.
REQ-006 The block SHALL have port datain, input, width, meaning DDR pad data.
REQ-007 The block SHALL have port align, input, 1, meaning a pulse that restarts word assembly at slot 0.
REQ-008 The block SHALL have ports dataout_h and dataout_l, output, width each, meaning the rising-edge and falling-edge samples of one beat.
REQ-009 The block SHALL have port beat_valid, output, 1, meaning dataout_h and dataout_l hold a new beat for this cycle.
REQ-010 The block SHALL have port word_out, output, 4*width, meaning two assembled beats.
REQ-011 The block SHALL have ports word_valid (output, 1) and word_ready (input, 1), forming a valid/ready handshake.
REQ-012 The block SHALL have port overflow, output, 1, meaning a sticky word-lost flag.

Function
REQ-013 rise_reg SHALL capture datain on each inclock rising edge where inclocken=1.
REQ-014 fall_reg SHALL capture datain on each falling edge that follows a rising edge where inclocken=1.
REQ-015 On rising edge N+1, dataout_h SHALL load the edge-N rise_reg sample and dataout_l SHALL load the fall_reg sample from the falling edge between N and N+1.
REQ-016 Beat latency SHALL be exactly one rising edge from the rising-edge sample to dataout.
REQ-017 beat_valid SHALL be 1 for exactly the cycle after an enabled capture pair.
REQ-018 While inclocken=0, dataout_h and dataout_l SHALL hold their values and beat_valid SHALL be 0.
REQ-019 The assembler SHALL be a 2-state FSM, SLOT0 and SLOT1, advancing only when beat_valid=1.
REQ-020 SLOT0: word_lo SHALL take {dataout_l, dataout_h}, then the FSM moves to SLOT1.
REQ-021 SLOT1: the assembled word {dataout_l, dataout_h, word_lo} SHALL complete, then the FSM moves to SLOT0.
REQ-022 The word SHALL place the first beat in the LSBs and, within each beat, h below l.
REQ-023 align=1 SHALL force the next state to SLOT0 and discard any partial word_lo.
REQ-024 If align=1 and beat_valid=1 occur in the same cycle, that beat SHALL be taken as slot 0, and the FSM SHALL move to SLOT1.
REQ-025 Output buffering SHALL be a single holding register whose EMPTY/FULL state drives word_valid.
REQ-026 A completed word SHALL load the holding register the cycle after completion if it is EMPTY, or if it is FULL and word_ready=1 that cycle (same-cycle drain-and-refill with no bubble).
REQ-027 A transfer SHALL occur when word_valid=1 and word_ready=1.
REQ-028 word_out SHALL remain stable while word_valid=1 and word_ready=0.
REQ-029 If a word completes while the holding register is FULL and word_ready=0, the new word SHALL be dropped, the held word kept, and overflow set.
REQ-030 overflow SHALL clear only on reset.

Reset
REQ-031 aclr_n=0 SHALL asynchronously force all of the following: rise_reg, fall_reg, dataout_h, dataout_l, word_lo and word_out to 0, or to all-ones when power_up_high="on"; beat_valid=0; word_valid=0; overflow=0; FSM=SLOT0; holding register EMPTY.
REQ-032 Reset deassertion SHALL take effect at the first rising edge with aclr_n=1.
REQ-033 Reset asserted mid-word or mid-handshake SHALL discard all partial and held data.

Verification
REQ-034 width=1, inclocken=1, datain rise=1 and fall=0 each cycle -> dataout_h=1, dataout_l=0 one edge later, and beat_valid high every cycle.
REQ-035 width=2, beats (h,l)=(1,2) then (3,0), word_ready=1 -> word_out=8'b00_11_10_01 with word_valid pulsed for 1 cycle.
REQ-036 Four beats with word_ready=0 -> first word held stable, overflow=1 after the second word completes, and the first word delivered when word_ready=1.
REQ-037 align pulse after one beat -> the partial word is discarded and the next two beats form word_out.
REQ-038 inclocken=0 for 3 cycles mid-word -> outputs are held, no beat_valid, and assembly resumes with the correct slot.
REQ-039 aclr_n low mid-word with power_up_high="on" -> data registers all-ones, word_valid=0, overflow=0, and FSM=SLOT0 immediately.
